// File: rtl/lock_fsm.sv
// Digital lock control FSM: collects a keypad code, compares it against CODE and drives the
// open window, wrong-code penalty and lockout, sequencing the external delay timer (timer1).
module lock_fsm #(
  parameter int unsigned CODE_LEN     = 4,
  parameter int unsigned DIGIT_W      = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 16'h1234,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned LOCK_PERIODS = 4,
  parameter int unsigned TRY_W        = 2
) (
  input  logic               clkdiv,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               relock,
  input  logic               t1in,
  output logic               t1en,
  output logic               t1out,
  output logic               unlocked,
  output logic               alarm,
  output logic               err,
  output logic [TRY_W-1:0]   tries,
  output logic [2:0]         state_o
);

  localparam int unsigned BufW = CODE_LEN * DIGIT_W;
  localparam int unsigned IdxW = $clog2(CODE_LEN + 1);
  localparam int unsigned LkW  = $clog2(LOCK_PERIODS + 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEntry   = 3'd1,
    StCheck   = 3'd2,
    StOpen    = 3'd3,
    StFail    = 3'd4,
    StLockout = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [BufW-1:0]   code_q, code_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [LkW-1:0]    lk_q, lk_d;
  logic [TRY_W-1:0]  tries_d;
  logic              err_d, restart, expired, timed_d, t1out_d;

  // The timer's expiry flag is stale during the clear cycle, so it only counts afterwards.
  assign expired = t1in & ~t1out;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    lk_d    = lk_q;
    tries_d = tries;
    err_d   = 1'b0;
    restart = 1'b0;
    case (state_q)
      StIdle: begin
        if (key_valid) begin
          code_d                    = '0;
          code_d[BufW-1 -: DIGIT_W] = key_digit;
          idx_d                     = IdxW'(1);
          state_d                   = StEntry;
        end
      end
      StEntry: begin
        if (key_valid) begin
          code_d[BufW - DIGIT_W * (int'(idx_q) + 1) +: DIGIT_W] = key_digit;
          if (idx_q == IdxW'(CODE_LEN - 1)) begin
            idx_d   = '0;
            err_d   = (code_d != CODE);
            state_d = StCheck;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            restart = 1'b1;
          end
        end else if (expired) begin
          code_d  = '0;
          idx_d   = '0;
          state_d = StIdle;
        end
      end
      StCheck: begin
        code_d = '0;
        if (code_q == CODE) begin
          tries_d = '0;
          state_d = StOpen;
        end else begin
          tries_d = (tries == TRY_W'(MAX_TRIES)) ? tries : tries + TRY_W'(1);
          state_d = (tries_d == TRY_W'(MAX_TRIES)) ? StLockout : StFail;
        end
      end
      StOpen: begin
        if (relock || expired) state_d = StIdle;
      end
      StFail: begin
        if (expired) state_d = StIdle;
      end
      StLockout: begin
        if (expired) begin
          if (lk_q == LkW'(LOCK_PERIODS - 1)) begin
            lk_d    = '0;
            tries_d = '0;
            state_d = StIdle;
          end else begin
            lk_d    = lk_q + LkW'(1);
            restart = 1'b1;
          end
        end
      end
      default: begin
        code_d  = '0;
        idx_d   = '0;
        lk_d    = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Timer is held in clear outside timed states and for the first cycle of every (re)start.
  assign timed_d = (state_d == StEntry) || (state_d == StOpen) ||
                   (state_d == StFail) || (state_d == StLockout);
  assign t1out_d = ~timed_d | restart | (state_d != state_q);

  always_ff @(posedge clkdiv or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      code_q   <= '0;
      idx_q    <= '0;
      lk_q     <= '0;
      tries    <= '0;
      err      <= 1'b0;
      t1out    <= 1'b1;
      t1en     <= 1'b0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      lk_q     <= lk_d;
      tries    <= tries_d;
      err      <= err_d;
      t1out    <= t1out_d;
      t1en     <= ~t1out_d;
      unlocked <= (state_d == StOpen);
      alarm    <= (state_d == StLockout);
    end
  end

  assign state_o = state_q;

endmodule

// File: doc/lock_fsm.md
Name: lock_fsm

Overview:
Main control state machine of the digital lock. It sits directly downstream of the keypad strobe logic and is the controlling neighbour of the delay timer (timer1). It consumes the timer's expiry flag (t1in) and drives the timer's enable and clear (t1out). It collects a digit sequence, compares it against a stored code, and manages the open window, wrong-code penalty delay and lockout after repeated failures.

Parameters:
CODE_LEN, 4, number of digits per code entry
DIGIT_W, 4, bits per digit
CODE, 16'h1234, correct code, CODE_LEN*DIGIT_W bits, first entered digit in MSBs
MAX_TRIES, 3, consecutive wrong entries that trigger lockout
LOCK_PERIODS, 4, timer expiries spent in LOCKOUT
TRY_W, 2, width of try counter (must hold MAX_TRIES)

Ports:
clkdiv  in  1  divided clock; all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 forces reset state immediately
key_valid  in  1  one-cycle strobe, key_digit valid
key_digit  in  DIGIT_W  digit value
relock  in  1  level; forces early relock while OPEN
t1in  in  1  timer expired (held high until cleared)
t1en  out  1  timer enable
t1out  out  1  timer clear, active-high
unlocked  out  1  lock actuator, 1 = open
alarm  out  1  high throughout LOCKOUT
err  out  1  one-cycle pulse on wrong code
tries  out  TRY_W  consecutive wrong-entry count
state_o  out  3  encoded state for debug: IDLE=0 ENTRY=1 CHECK=2 OPEN=3 FAIL=4 LOCKOUT=5

Behaviour:
- Reset (reset=0, async): state IDLE; t1out=1; t1en=0, unlocked=0, alarm=0, err=0, tries=0; digit buffer, index and lockout counter cleared. Takes effect without a clock edge.
- All outputs registered; no combinational path from inputs to outputs.
- Timer handshake: on every entry into a timed state (ENTRY, OPEN, FAIL, LOCKOUT), t1out=1 and t1en=0 for exactly the first cycle in the state. From the next cycle on, t1out=0 and t1en=1. t1in is ignored during the clear cycle.
- Restarting the timer from within a state re-issues that same one-cycle clear.
- IDLE: t1out=1, t1en=0. key_valid stores digit 0, index=1, next state ENTRY. t1in and relock are ignored.
- ENTRY (inter-key timeout):
  - key_valid stores the digit at index, increments index and restarts the timer.
  - When the stored digit completes CODE_LEN digits, next state is CHECK.
  - t1in=1 with no key_valid: timeout, go IDLE, buffer cleared, tries unchanged.
  - key_valid and t1in in the same cycle: the key wins and the timer restarts.
- CHECK (exactly 1 cycle):
  - Buffer equals CODE: go OPEN, tries cleared to 0.
  - Otherwise: err=1 for this one cycle and tries increments. If the new count equals MAX_TRIES, go LOCKOUT; else go FAIL.
  - key_valid during CHECK is dropped.
- OPEN: unlocked=1 from the first cycle in the state. t1in=1 or relock=1 goes IDLE, and unlocked=0 from the IDLE cycle. key_valid is ignored.
- FAIL: penalty delay of one timer period. key_valid is ignored; t1in=1 goes IDLE.
- LOCKOUT:
  - alarm=1 and key_valid is ignored.
  - Each t1in=1 increments the lockout counter and restarts the timer.
  - On the LOCK_PERIODS-th expiry: go IDLE, tries=0, alarm=0.
- tries saturates at MAX_TRIES and is never reset by timeout or by FAIL exit.
- Reset mid-operation (any state) returns to the reset state, including unlocked=0 and alarm=0 asynchronously.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
- Correct entry: reset, then key_valid with digits 1,2,3,4 on consecutive strobes. Required: state ENTRY then CHECK, unlocked=1 from the cycle after CHECK, err stays 0, tries=0. Force t1in=1 and unlocked drops to 0 next edge with state IDLE.
- Wrong entry: enter 1,2,3,5. Required: err pulses for exactly 1 cycle, tries=1, state FAIL with a t1out one-cycle clear. Keys entered in FAIL are ignored. t1in returns the FSM to IDLE.
- Lockout: three wrong codes in a row. Required: tries=3, alarm=1, state LOCKOUT. With LOCK_PERIODS=4, exactly 4 t1in pulses are needed, each followed by a 1-cycle t1out. After the 4th: IDLE, tries=0, alarm=0.
- Inter-key timeout: enter 1,2, then assert t1in. Required: IDLE, tries unchanged. A subsequent 1,2,3,4 opens the lock (buffer was cleared).
- Simultaneous events: in ENTRY, assert key_valid and t1in in the same cycle. Required: the digit is accepted, t1out=1 the next cycle, no timeout. In OPEN, relock=1 gives IDLE next edge.
- Async reset: drop reset mid-OPEN between clock edges. Required: unlocked=0 and t1out=1 immediately with no edge, and state_o=0.
